// File: rtl/aes_inv_shift_mix.sv
// Inverse-cipher round stage: InvShiftRows at capture, then InvMixColumns one
// column per cycle, with a per-transaction bypass for the final round.
module aes_inv_shift_mix #(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         bypass_mix,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MIX  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       state_r;
    logic [1:0]   col_r;
    logic [127:0] work_r;
    logic [127:0] out_state_r;
    logic         in_ready_r;
    logic         out_valid_r;

    logic         accept_s;
    logic [127:0] shifted_s;
    logic [31:0]  work_col_s;
    logic [31:0]  mixed_col_s;
    logic [127:0] next_out_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_9(input logic [7:0] b);
        mul_9 = xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul_b(input logic [7:0] b);
        mul_b = xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul_d(input logic [7:0] b);
        mul_d = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul_e(input logic [7:0] b);
        mul_e = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Column is {a0,a1,a2,a3} with a0 in the top byte (row 0).
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        inv_mix_col = {mul_e(a0) ^ mul_b(a1) ^ mul_d(a2) ^ mul_9(a3),
                       mul_e(a1) ^ mul_b(a2) ^ mul_d(a3) ^ mul_9(a0),
                       mul_e(a2) ^ mul_b(a3) ^ mul_d(a0) ^ mul_9(a1),
                       mul_e(a3) ^ mul_b(a0) ^ mul_d(a1) ^ mul_9(a2)};
    endfunction

    // Row r rotates right by r: out(r,c) = in(r,(c-r) mod 4).
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        inv_shift_rows = {s[127:120], s[23:16],   s[47:40],  s[71:64],
                          s[95:88],   s[119:112], s[15:8],   s[39:32],
                          s[63:56],   s[87:80],   s[111:104], s[7:0],
                          s[31:24],   s[55:48],   s[79:72],  s[103:96]};
    endfunction

    assign accept_s  = in_valid && in_ready_r;
    assign shifted_s = inv_shift_rows(in_state);

    // Select the working column, mix it, and merge it into the output image.
    always_comb begin
        work_col_s = 32'h0000_0000;
        next_out_s = out_state_r;
        case (col_r)
            2'd0:    work_col_s = work_r[127:96];
            2'd1:    work_col_s = work_r[95:64];
            2'd2:    work_col_s = work_r[63:32];
            2'd3:    work_col_s = work_r[31:0];
            default: work_col_s = 32'h0000_0000;
        endcase
        mixed_col_s = inv_mix_col(work_col_s);
        case (col_r)
            2'd0:    next_out_s[127:96] = mixed_col_s;
            2'd1:    next_out_s[95:64]  = mixed_col_s;
            2'd2:    next_out_s[63:32]  = mixed_col_s;
            2'd3:    next_out_s[31:0]   = mixed_col_s;
            default: next_out_s = out_state_r;
        endcase
    end

    // Control FSM with registered handshake outputs and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            col_r       <= 2'd0;
            work_r      <= 128'h0;
            out_state_r <= 128'h0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        work_r     <= shifted_s;
                        in_ready_r <= 1'b0;
                        if (bypass_mix && BYPASS_EN) begin
                            out_state_r <= shifted_s;
                            out_valid_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end else begin
                            col_r   <= 2'd0;
                            state_r <= ST_MIX;
                        end
                    end
                end
                ST_MIX: begin
                    out_state_r <= next_out_s;
                    col_r       <= col_r + 2'd1;
                    // Column 3 is the last; the counter wraps to 0 here too.
                    if (col_r == 2'd3) begin
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    col_r       <= 2'd0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_state = out_state_r;

    aes_inv_shift_mix_chk u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_ready  (in_ready_r),
        .out_valid (out_valid_r),
        .out_ready (out_ready),
        .out_state (out_state_r),
        .state     (state_r),
        .col       (col_r)
    );

endmodule

// Handshake and sequencing invariants for aes_inv_shift_mix (assertions only).
module aes_inv_shift_mix_chk (
    input logic         clk,
    input logic         rst_n,
    input logic         in_ready,
    input logic         out_valid,
    input logic         out_ready,
    input logic [127:0] out_state,
    input logic [1:0]   state,
    input logic [1:0]   col
);

    // Accepting and presenting are mutually exclusive (no overlap).
    a_ready_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && out_valid));

    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_state)));

    a_col_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (state != 2'd1) |-> (col == 2'd0));

endmodule

// File: tb/tb_aes_inv_shift_mix.sv
// Directed and streaming checks for aes_inv_shift_mix, with a bit-serial
// GF(2^8) reference model for the non-hand-computed results.
module tb_aes_inv_shift_mix;

    localparam logic [127:0] BYP_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] BYP_EXP = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] MIX_IN  = 128'h04cbd34ce0f826e54806819a2866197a;
    localparam logic [127:0] MIX_EXP = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam int           N_STREAM = 1000;

    logic         clk;
    logic         rst_n;
    logic         a_in_valid, a_in_ready, a_bypass, a_out_valid, a_out_ready;
    logic [127:0] a_in_state, a_out_state;
    logic         b_in_valid, b_in_ready, b_bypass, b_out_valid, b_out_ready;
    logic [127:0] b_in_state, b_out_state;

    int vectors;
    int miscompares;

    aes_inv_shift_mix #(.BYPASS_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_state(a_in_state),
        .bypass_mix(a_bypass), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_state(a_out_state)
    );

    aes_inv_shift_mix #(.BYPASS_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_state(b_in_state),
        .bypass_mix(b_bypass), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_state(b_out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] st, input int r, input int c);
        return 8'(st >> (8 * (15 - (4 * c + r))));
    endfunction

    function automatic logic [127:0] pb(input logic [7:0] v, input int r, input int c);
        return {120'h0, v} << (8 * (15 - (4 * c + r)));
    endfunction

    function automatic logic [127:0] ref_isr(input logic [127:0] st);
        logic [127:0] res;
        res = 128'h0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                res = res | pb(gb(st, r, (c - r + 4) % 4), r, c);
        return res;
    endfunction

    function automatic logic [127:0] ref_imc(input logic [127:0] st);
        logic [127:0] res;
        logic [7:0]   v;
        res = 128'h0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                v = gmul(gb(st, r, c), 8'h0e) ^ gmul(gb(st, (r + 1) % 4, c), 8'h0b) ^
                    gmul(gb(st, (r + 2) % 4, c), 8'h0d) ^ gmul(gb(st, (r + 3) % 4, c), 8'h09);
                res = res | pb(v, r, c);
            end
        return res;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_state = 128'h0; a_bypass = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_state = 128'h0; b_bypass = 1'b0; b_out_ready = 1'b0;
        repeat (2) step();
        vectors++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_state !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_a: rdy=%b vld=%b state=%h want 1 0 0", a_in_ready, a_out_valid, a_out_state);
        end
        vectors++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_out_state !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_b: rdy=%b vld=%b state=%h want 1 0 0", b_in_ready, b_out_valid, b_out_state);
        end
        @(negedge clk) rst_n = 1'b1;
        step();
    endtask

    task automatic test_bypass();
        a_in_state = BYP_IN; a_bypass = 1'b1; a_out_ready = 1'b1; a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0; a_bypass = 1'b0;
        vectors++;
        if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_latency: vld=%b rdy=%b want 1 0", a_out_valid, a_in_ready);
        end
        vectors++;
        if (a_out_state !== BYP_EXP) begin
            miscompares++;
            $display("FAIL bypass_data: got %h want %h", a_out_state, BYP_EXP);
        end
        step();
        vectors++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bypass_release: vld=%b rdy=%b want 0 1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_full_path();
        a_in_state = MIX_IN; a_bypass = 1'b0; a_out_ready = 1'b1; a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            vectors++;
            if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL mix_busy_%0d: vld=%b rdy=%b want 0 0", k, a_out_valid, a_in_ready);
            end
            step();
        end
        vectors++;
        if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_out_state !== MIX_EXP) begin
            miscompares++;
            $display("FAIL mix_result: vld=%b rdy=%b got %h want 1 0 %h", a_out_valid, a_in_ready, a_out_state, MIX_EXP);
        end
        step();
        vectors++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_state !== MIX_EXP) begin
            miscompares++;
            $display("FAIL mix_release: vld=%b rdy=%b got %h want 0 1 %h", a_out_valid, a_in_ready, a_out_state, MIX_EXP);
        end
    endtask

    task automatic test_backpressure();
        a_in_state = MIX_IN; a_bypass = 1'b0; a_out_ready = 1'b0; a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        repeat (4) step();
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin a_in_valid = 1'b1; a_in_state = BYP_IN; a_bypass = 1'b1; end
            if (k == 4) begin a_in_valid = 1'b0; a_bypass = 1'b0; end
            vectors++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_out_state !== MIX_EXP) begin
                miscompares++;
                $display("FAIL backpressure_hold_%0d: vld=%b rdy=%b got %h want 1 0 %h", k, a_out_valid, a_in_ready, a_out_state, MIX_EXP);
            end
            step();
        end
        a_out_ready = 1'b1;
        step();
        vectors++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_state !== MIX_EXP) begin
            miscompares++;
            $display("FAIL backpressure_release: vld=%b rdy=%b got %h want 0 1 %h", a_out_valid, a_in_ready, a_out_state, MIX_EXP);
        end
        step();
        vectors++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure_no_accept: vld=%b rdy=%b want 0 1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_no_bypass_param();
        logic [127:0] exp;
        exp = ref_imc(ref_isr(BYP_IN));
        b_in_state = BYP_IN; b_bypass = 1'b1; b_out_ready = 1'b1; b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0; b_bypass = 1'b0;
        vectors++;
        if (b_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL nobypass_early: vld=%b want 0", b_out_valid);
        end
        repeat (3) step();
        vectors++;
        if (b_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL nobypass_edge3: vld=%b want 0", b_out_valid);
        end
        step();
        vectors++;
        if (b_out_valid !== 1'b1 || b_out_state !== exp) begin
            miscompares++;
            $display("FAIL nobypass_result: vld=%b got %h want 1 %h", b_out_valid, b_out_state, exp);
        end
        step();
    endtask

    task automatic test_reset_mid_mix();
        logic [127:0] exp;
        exp = MIX_EXP;
        a_in_state = MIX_IN; a_bypass = 1'b0; a_out_ready = 1'b1; a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        step();
        vectors++;
        if (a_out_state[127:96] !== exp[127:96]) begin
            miscompares++;
            $display("FAIL col0_written: got %h want %h", a_out_state[127:96], exp[127:96]);
        end
        step();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_state !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_mid_mix: vld=%b rdy=%b got %h want 0 1 0", a_out_valid, a_in_ready, a_out_state);
        end
        @(negedge clk) rst_n = 1'b1;
        step();
        a_in_state = MIX_IN; a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        repeat (4) step();
        vectors++;
        if (a_out_valid !== 1'b1 || a_out_state !== MIX_EXP) begin
            miscompares++;
            $display("FAIL after_reset_mix: vld=%b got %h want 1 %h", a_out_valid, a_out_state, MIX_EXP);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [127:0] expq[$];
        logic [127:0] exp;
        int sent, got, cyc;
        logic acc, hs;
        sent = 0; got = 0; cyc = 0;
        a_in_valid = 1'b0;
        while (got < N_STREAM && cyc < 30000) begin
            if (!a_in_valid && sent < N_STREAM && $urandom_range(0, 3) != 0) begin
                a_in_valid = 1'b1;
                a_in_state = {$urandom, $urandom, $urandom, $urandom};
                a_bypass   = 1'($urandom_range(0, 1));
            end
            a_out_ready = ($urandom_range(0, 3) != 0);
            acc = a_in_valid && a_in_ready;
            hs  = a_out_valid && a_out_ready;
            if (hs) begin
                vectors++;
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream_extra: unexpected output %h", a_out_state);
                end else begin
                    exp = expq.pop_front();
                    if (a_out_state !== exp) begin
                        miscompares++;
                        $display("FAIL stream_data_%0d: got %h want %h", got, a_out_state, exp);
                    end
                end
                got++;
            end
            if (acc) expq.push_back(a_bypass ? ref_isr(a_in_state) : ref_imc(ref_isr(a_in_state)));
            step();
            cyc++;
            if (acc) begin
                a_in_valid = 1'b0;
                sent++;
            end
        end
        vectors++;
        if (got != N_STREAM || sent != N_STREAM || expq.size() != 0) begin
            miscompares++;
            $display("FAIL stream_count: sent=%0d got=%0d pending=%0d cycles=%0d want %0d %0d 0", sent, got, expq.size(), cyc, N_STREAM, N_STREAM);
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        repeat (6) step();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_bypass();
        test_full_path();
        test_backpressure();
        test_no_bypass_param();
        test_reset_mid_mix();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
